div_seq_responder: RTL and testbench

- Multi-cycle radix-2 restoring divider; the responder side of the EX-stage divide valid/ready handshake.
- The ALU raises opn_valid for DIV/DIVU and stalls EX until res_valid.
- Block returns {remainder, quotient} as the 64-bit HI/LO write value.
- Sits beside the combinational multiplier inside the execute stage.

---
 rtl/div_seq_responder.sv | 163 ++++++++++++++++
 tb/tb_div_seq_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq_responder.sv
// Multi-cycle radix-2 restoring divider answering the EX-stage divide valid/ready handshake.
// Optional macro DIV_EARLY_OUT_EN skips CALC when the divisor is zero or exceeds the dividend.
module div_seq_responder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  input  logic               opn_valid,
  input  logic               res_ready,
  output logic               res_valid,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       shift_s, trial_s;

  // next-state, datapath step and registered-output staging
  always_comb begin
    a_mag_s     = cond_neg(a, sign & a[WIDTH-1]);
    b_mag_s     = cond_neg(b, sign & b[WIDTH-1]);
    shift_s     = {rem_q, quo_q[WIDTH-1]};
    trial_s     = shift_s - {1'b0, dvs_q};
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (opn_valid) begin
          state_d = CALC;
          dvs_d   = b_mag_s;
          rneg_d  = sign & a[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
          // Trivial operands: preload so the final correction step yields {a, q} on E1.
          if ((b_mag_s == {WIDTH{1'b0}}) || (a_mag_s < b_mag_s)) begin
            cnt_d  = CNT_ZERO;
            rem_d  = a_mag_s;
            quo_d  = (b_mag_s == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            qneg_d = 1'b0;
          end else begin
            cnt_d  = CNT_INIT;
            rem_d  = {WIDTH{1'b0}};
            quo_d  = a_mag_s;
            qneg_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
`else
          cnt_d  = CNT_INIT;
          rem_d  = {WIDTH{1'b0}};
          quo_d  = a_mag_s;
          qneg_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (!opn_valid) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          result_d    = {cond_neg(rem_q, rneg_q), cond_neg(quo_q, qneg_q)};
        end else begin
          // quo_q doubles as the dividend shifter: dividend bits leave the top, quotient bits enter the bottom
          cnt_d = cnt_q - CNT_ONE;
          if (!trial_s[WIDTH]) begin
            rem_d = trial_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shift_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= {(2*WIDTH){1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div_seq_responder.sv
// Self-checking bench for div_seq_responder: constant vector table, random ops against a
// reference model, and hand-written reset/abort/backpressure sequences; honours DIV_EARLY_OUT_EN.
module tb_div_seq_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        sign, opn_valid, res_ready;
  logic        res_valid, busy;
  logic [63:0] result;

  always #5 clk = ~clk;

  div_seq_responder #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sign(sign), .opn_valid(opn_valid),
    .res_ready(res_ready), .res_valid(res_valid), .result(result), .busy(busy)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic [63:0] vexp;
  } vec_t;

  vec_t        vec [10];
  logic [63:0] exp_q [$];
  int          lat_q [$];
  int          n_checks = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    logic [31:0] q, r;
    if (mb == 32'd0) begin
`ifdef DIV_EARLY_OUT_EN
      q = 32'hFFFF_FFFF;
`else
      q = (ms && ma[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
      r = ma;
    end else if (!ms) begin
      q = ma / mb;
      r = ma % mb;
    end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $unsigned($signed(ma) / $signed(mb));
      r = $unsigned($signed(ma) % $signed(mb));
    end
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] am, bm;
    am = (ms && ma[31]) ? (~ma + 32'd1) : ma;
    bm = (ms && mb[31]) ? (~mb + 32'd1) : mb;
    if (bm == 32'd0 || am < bm) return 1;
`endif
    return 33;
  endfunction

  task automatic drive_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, input logic [63:0] texp);
    a = ta; b = tb_; sign = ts; opn_valid = 1'b1;
    exp_q.push_back(texp);
    lat_q.push_back(exp_lat(ta, tb_, ts));
  endtask

  // Next posedge is the accepting edge E0; runs the op through its handshake.
  task automatic run_op(input int hold, input logic early_ready, input logic chain,
                        input logic [31:0] na, input logic [31:0] nb, input logic ns, input logic [63:0] nexp);
    logic [63:0] exp_r;
    int lat, exp_l;
    @(posedge clk); #1;
    check("accept_busy", {63'd0, busy}, 64'd1);
    a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
    res_ready = early_ready;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    check("latency", 64'(lat), 64'(exp_l));
    check("result", result, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, res_valid}, 64'd1);
      check("hold_result", result, exp_r);
    end
    res_ready = 1'b1;
    if (chain) drive_op(na, nb, ns, nexp);
    else opn_valid = 1'b0;
    @(posedge clk); #1;
    check("hs_valid", {63'd0, res_valid}, 64'd0);
    check("hs_busy", {63'd0, busy}, 64'd0);
    check("hs_result", result, exp_r);
    res_ready = 1'b0;
  endtask

  initial begin
    int rv_seen;
    logic [31:0] ra, rb;
    logic rs;
    vec[0] = '{32'd100,        32'd7,          1'b0, 64'h0000_0002_0000_000E};
    vec[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFF_FFFF_FFFF_FFFD};
    vec[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_8000_0000};
    vec[3] = '{32'h1234_5678,  32'd0,          1'b0, 64'h1234_5678_FFFF_FFFF};
    vec[4] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'h0000_0001_FFFF_FFFD};
    vec[5] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 64'hFFFF_FFFF_0000_0003};
    vec[6] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 64'h0000_0001_7FFF_FFFC};
    vec[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 64'h0000_0000_FFFF_FFFF};
    vec[8] = '{32'd3,          32'd9,          1'b0, 64'h0000_0003_0000_0000};
`ifdef DIV_EARLY_OUT_EN
    vec[9] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 64'hFFFF_FFF9_FFFF_FFFF};
`else
    vec[9] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 64'hFFFF_FFF9_0000_0001};
`endif

    // reset wins over a pending operation
    rst = 1'b1; a = 32'd5; b = 32'd1; sign = 1'b0; opn_valid = 1'b1; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, res_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0; opn_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      drive_op(vec[i].va, vec[i].vb, vec[i].vs, vec[i].vexp);
      run_op(i % 3, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    end

    // backpressure for 5 cycles, then a chained op that must wait one edge past the handshake
    drive_op(32'd1000, 32'd10, 1'b0, 64'h0000_0000_0000_0064);
    run_op(5, 1'b0, 1'b1, 32'd77, 32'd7, 1'b0, 64'h0000_0000_0000_000B);
    run_op(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = 1'($urandom_range(0, 1));
      drive_op(ra, rb, rs, model(ra, rb, rs));
      run_op(0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    end

    // reset at E10 of an in-flight divide
    a = 32'd1234567; b = 32'd3; sign = 1'b0; opn_valid = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {63'd0, res_valid}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    drive_op(32'd50, 32'd5, 1'b0, 64'h0000_0000_0000_000A);
    run_op(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 64'd0);

    // abort: opn_valid dropped after E15
    a = 32'd1000; b = 32'd3; sign = 1'b0; opn_valid = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    opn_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_after", {63'd0, busy}, 64'd0);
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_valid) rv_seen++;
    end
    check("abort_no_valid", 64'(rv_seen), 64'd0);
    check("abort_result_kept", result, 64'h0000_0000_0000_000A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
